// File: rtl/seg_capture.sv
// Multiplexed 7-segment scan capture: debounces each digit select,
// decodes segments to BCD and commits a full 8-digit frame once all are seen.
module seg_capture #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_seg_d,
  input  logic [7:0]  i_seg_com,
  output logic [31:0] o_bcd8d,
  output logic [7:0]  o_dp,
  output logic        o_frame_valid,
  output logic        o_seg_err,
  output logic        o_active
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] SETTLE_N = CW'(SETTLE_CYC);
  localparam logic [TW-1:0] TMO_N    = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  logic [7:0]    seg_q, com_q, pseg_q, pcom_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    sdp_q, sdp_d;
  logic [7:0]    dp_q, dp_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   bcd_q, bcd_d;
  logic          fv_q, fv_d;
  logic          done_q, done_d;
  logic          legal, chg, cap, bad, tmo_sat, commit;
  logic [2:0]    idx;
  logic [3:0]    nib;

  assign legal   = $onehot(~com_q);
  assign chg     = (seg_q != pseg_q) || (com_q != pcom_q);
  assign tmo_sat = (tmo_q == TMO_N);
  assign commit  = &mask_q;

  // Reset sample uses an all-high select so the first legal digit is a change
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_q  <= '0;
      com_q  <= 8'hFF;
      pseg_q <= '0;
      pcom_q <= 8'hFF;
    end else begin
      seg_q  <= i_seg_d;
      com_q  <= i_seg_com;
      pseg_q <= seg_q;
      pcom_q <= com_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (legal) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (!chg) begin
          cnt_d = cnt_q + 1'b1;
        end else if (legal) begin
          cnt_d = CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (chg) begin
          state_d = legal ? SETTLE : IDLE;
          cnt_d   = legal ? CW'(1) : '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == SETTLE && cnt_d == SETTLE_N)
      state_d = HOLD;
  end

  always_comb begin
    cap = (state_d == HOLD) && (state_q != HOLD || chg);
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (!com_q[i]) idx = 3'(i);
    bad = 1'b0;
    nib = 4'hE;
    case (seg_q[6:0])
      7'h3F:   nib = 4'h0;
      7'h06:   nib = 4'h1;
      7'h5B:   nib = 4'h2;
      7'h4F:   nib = 4'h3;
      7'h66:   nib = 4'h4;
      7'h6D:   nib = 4'h5;
      7'h7D:   nib = 4'h6;
      7'h07:   nib = 4'h7;
      7'h7F:   nib = 4'h8;
      7'h6F:   nib = 4'h9;
      7'h00:   nib = 4'hF;
      default: bad = 1'b1;
    endcase
    o_seg_err = cap && bad;
    o_active  = done_q && !tmo_sat;
  end

  // Commit reads the old shadow, so a same-cycle capture lands in the next frame
  always_comb begin
    mask_d   = mask_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    bcd_d    = bcd_q;
    dp_d     = dp_q;
    fv_d     = 1'b0;
    done_d   = done_q;
    if (commit) begin
      bcd_d  = shadow_q;
      dp_d   = sdp_q;
      fv_d   = 1'b1;
      done_d = 1'b1;
    end
    if (commit || tmo_sat)
      mask_d = '0;
    if (cap) begin
      shadow_d[{idx, 2'b00} +: 4] = nib;
      sdp_d[idx]  = seg_q[7];
      mask_d[idx] = 1'b1;
    end
    if (cap)
      tmo_d = '0;
    else if (tmo_sat)
      tmo_d = tmo_q;
    else
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mask_q   <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      bcd_q    <= 32'hFFFF_FFFF;
      dp_q     <= '0;
      fv_q     <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      bcd_q    <= bcd_d;
      dp_q     <= dp_d;
      fv_q     <= fv_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_bcd8d       = bcd_q;
  assign o_dp          = dp_q;
  assign o_frame_valid = fv_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: run-length reference model of the sampled scan
// stream, checked every cycle, plus literal expectations per scenario.
module tb_seg_capture;

  localparam int S = 4;
  localparam int T = 200;

  logic        clk;
  logic        rst;
  logic [7:0]  seg;
  logic [7:0]  com;
  logic [31:0] o_bcd8d;
  logic [7:0]  o_dp;
  logic        o_frame_valid;
  logic        o_seg_err;
  logic        o_active;

  seg_capture #(
    .SETTLE_CYC  (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_seg_d       (seg),
    .i_seg_com     (com),
    .o_bcd8d       (o_bcd8d),
    .o_dp          (o_dp),
    .o_frame_valid (o_frame_valid),
    .o_seg_err     (o_seg_err),
    .o_active      (o_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state: the registered sample, its run length, and the frame data
  logic [7:0]  m_seg, m_com;
  int          m_run;
  logic [3:0]  m_nib [8];
  logic        m_sdp [8];
  logic        m_msk [8];
  logic [31:0] m_out;
  logic [7:0]  m_dp;
  logic        m_fv, m_done;
  int          m_tmo;

  function automatic logic [3:0] dec(input logic [6:0] s);
    if (s == 7'h00) return 4'hF;
    for (int d = 0; d < 10; d++)
      if (pat[d] == s) return 4'(d);
    return 4'hE;
  endfunction

  function automatic bit legal(input logic [7:0] c);
    return $countones(~c) == 1;
  endfunction

  function automatic int pos(input logic [7:0] c);
    for (int i = 0; i < 8; i++)
      if (!c[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] seg_of(input int d);
    if (d < 10) return {1'b0, pat[d]};
    return 8'h00;
  endfunction

  function automatic logic [7:0] com_of(input int n);
    logic [7:0] c;
    c = 8'hFF;
    c[n] = 1'b0;
    return c;
  endfunction

  function automatic bit m_cap();
    return legal(m_com) && (m_run == S);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      pass_n++;
  endtask

  task automatic model_reset();
    m_seg = 8'h00;
    m_com = 8'hFF;
    m_run = 1;
    for (int i = 0; i < 8; i++) begin
      m_nib[i] = 4'h0;
      m_sdp[i] = 1'b0;
      m_msk[i] = 1'b0;
    end
    m_out  = 32'hFFFF_FFFF;
    m_dp   = 8'h00;
    m_fv   = 1'b0;
    m_done = 1'b0;
    m_tmo  = 0;
  endtask

  // Advance the model across one rising edge using the driven inputs
  task automatic model_step();
    bit cap, full;
    int k;
    if (rst) begin
      model_reset();
      return;
    end
    cap  = m_cap();
    full = 1;
    for (int i = 0; i < 8; i++)
      if (!m_msk[i]) full = 0;
    m_fv = full;
    if (full) begin
      for (int i = 0; i < 8; i++) begin
        m_out[4*i +: 4] = m_nib[i];
        m_dp[i] = m_sdp[i];
      end
      m_done = 1'b1;
    end
    if (full || m_tmo >= T)
      for (int i = 0; i < 8; i++) m_msk[i] = 1'b0;
    if (cap) begin
      k = pos(m_com);
      m_nib[k] = dec(m_seg[6:0]);
      m_sdp[k] = m_seg[7];
      m_msk[k] = 1'b1;
      m_tmo = 0;
    end else if (m_tmo < T) begin
      m_tmo++;
    end
    if (seg == m_seg && com == m_com) m_run++;
    else m_run = 1;
    m_seg = seg;
    m_com = com;
  endtask

  task automatic check_all();
    logic exp_err;
    exp_err = m_cap() && (dec(m_seg[6:0]) == 4'hE);
    chk("bcd8d", o_bcd8d, m_out);
    chk("dp", 32'(o_dp), 32'(m_dp));
    chk("frame_valid", 32'(o_frame_valid), 32'(m_fv));
    chk("seg_err", 32'(o_seg_err), 32'(exp_err));
    chk("active", 32'(o_active), 32'(m_done && (m_tmo < T)));
    if (o_frame_valid) fv_cnt++;
    if (o_seg_err) err_cnt++;
  endtask

  task automatic tick(input logic [7:0] s, input logic [7:0] c);
    @(negedge clk);
    check_all();
    seg = s;
    com = c;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_all();
    rst = 1'b1;
    #1;
    chk("rst_bcd8d", o_bcd8d, 32'hFFFF_FFFF);
    chk("rst_dp", 32'(o_dp), 32'h0);
    chk("rst_fv", 32'(o_frame_valid), 32'h0);
    chk("rst_err", 32'(o_seg_err), 32'h0);
    chk("rst_active", 32'(o_active), 32'h0);
    model_step();
    repeat (2) tick(8'h00, 8'hFF);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    seg = 8'h00;
    com = 8'hFF;
    model_step();
  endtask

  task automatic scan(input logic [7:0] s [8], input int hold,
                      input int gap, input int first, input int last);
    for (int n = first; n <= last; n++) begin
      repeat (hold) tick(s[n], com_of(n));
      repeat (gap) tick(8'h00, 8'hFC);
    end
  endtask

  logic [7:0] sa [8];
  logic [7:0] sb [8];
  int f0, e0;
  logic [31:0] held;

  initial begin
    rst = 1'b1;
    seg = 8'h00;
    com = 8'hFF;
    model_reset();
    for (int n = 0; n < 8; n++) begin
      sa[n] = seg_of(8 - n);
      sb[n] = seg_of(n + 1);
    end

    do_reset();

    // "12345678", 10 cycles per digit
    f0 = fv_cnt;
    scan(sa, 10, 0, 0, 7);
    repeat (4) tick(8'h00, 8'hFF);
    chk("frame_count_basic", 32'(fv_cnt - f0), 32'd1);
    chk("bcd_basic", o_bcd8d, 32'h1234_5678);
    chk("dp_basic", 32'(o_dp), 32'h0);
    chk("active_basic", 32'(o_active), 32'h1);

    // Scan stops: o_active must drop, data held
    held = o_bcd8d;
    repeat (T + 10) tick(8'h00, 8'hFF);
    chk("timeout_active", 32'(o_active), 32'h0);
    chk("timeout_hold", o_bcd8d, held);

    // Digit 2 held too briefly
    do_reset();
    f0 = fv_cnt;
    for (int n = 0; n < 8; n++)
      repeat (n == 2 ? S - 1 : 10) tick(sb[n], com_of(n));
    repeat (4) tick(8'h00, 8'hFF);
    chk("short_no_frame", 32'(fv_cnt - f0), 32'd0);
    repeat (6) tick(sb[2], com_of(2));
    repeat (4) tick(8'h00, 8'hFF);
    chk("short_rescan_frame", 32'(fv_cnt - f0), 32'd1);
    chk("short_bcd", o_bcd8d, 32'h8765_4321);

    // Undecodable digit 3 with dp set
    e0 = err_cnt;
    f0 = fv_cnt;
    sa[3] = 8'hC9;
    scan(sa, 10, 0, 0, 7);
    repeat (4) tick(8'h00, 8'hFF);
    chk("err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("err_frame", 32'(fv_cnt - f0), 32'd1);
    chk("err_bcd", o_bcd8d, 32'h1234_E678);
    chk("err_dp", 32'(o_dp), 32'h08);
    sa[3] = seg_of(5);

    // Two selects low between digits
    f0 = fv_cnt;
    scan(sa, 10, 20, 0, 7);
    repeat (4) tick(8'h00, 8'hFF);
    chk("gap_frame", 32'(fv_cnt - f0), 32'd1);
    chk("gap_bcd", o_bcd8d, 32'h1234_5678);

    // Reset after 5 digits; partial captures discarded
    scan(sb, 10, 0, 0, 4);
    do_reset();
    f0 = fv_cnt;
    scan(sb, 10, 0, 5, 7);
    repeat (4) tick(8'h00, 8'hFF);
    chk("rst_partial_no_frame", 32'(fv_cnt - f0), 32'd0);
    chk("rst_partial_bcd", o_bcd8d, 32'hFFFF_FFFF);
    scan(sb, 10, 0, 0, 7);
    repeat (4) tick(8'h00, 8'hFF);
    chk("rst_full_frame", 32'(fv_cnt - f0), 32'd1);
    chk("rst_full_bcd", o_bcd8d, 32'h8765_4321);

    // Random scan traffic
    for (int i = 0; i < 400; i++) begin
      int n, h, r;
      logic [7:0] s, c;
      n = $urandom_range(0, 7);
      h = $urandom_range(1, 8);
      c = com_of(n);
      if ($urandom_range(0, 9) == 0) c = 8'($urandom);
      r = $urandom_range(0, 19);
      if (r < 17)
        s = seg_of($urandom_range(0, 10)) | {$urandom_range(0, 1) == 1, 7'h0};
      else
        s = 8'($urandom);
      repeat (h) tick(s, c);
      if (i == 200) do_reset();
    end
    repeat (4) tick(8'h00, 8'hFF);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter SETTLE_CYC, default 4: consecutive identical samples needed before a digit is captured.
REQ-002 Parameter TIMEOUT_CYC, default 1000000: cycles without a legal digit change before the scan is declared dead.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_seg_d  input  8  segment bus {dp,g,f,e,d,c,b,a}, active-high.
REQ-006 i_seg_com  input  8  digit select, active-low one-hot; com[n] low selects digit n, digit 0 = least significant.
REQ-007 o_bcd8d  output  32  reconstructed nibbles; digit n in bits [4n+3:4n].
REQ-008 o_dp  output  8  decimal point per digit, bit n = digit n.
REQ-009 o_frame_valid  output  1  one-cycle pulse when o_bcd8d/o_dp update.
REQ-010 o_seg_err  output  1  one-cycle pulse when an undecodable pattern is captured.
REQ-011 o_active  output  1  high while the scan is alive.

Function
REQ-012 i_seg_d and i_seg_com SHALL be registered once; all logic operates on the registered copies.
REQ-013 Legal select: exactly one bit of the registered com low; all-high (blanking) or more than one low is illegal.
REQ-014 FSM states: IDLE, SETTLE, HOLD.
REQ-015 IDLE: illegal select -> stay; legal select -> SETTLE, settle counter = 1.
REQ-016 SETTLE: com and seg equal previous sample -> counter +1; any change -> counter = 1, stay in SETTLE if still legal, else IDLE.
REQ-017 Counter reaching SETTLE_CYC SHALL capture the digit into a shadow register the same cycle, set its mask bit, and go to HOLD.
REQ-018 HOLD: no change -> stay, no further capture; legal select or seg change -> SETTLE, counter = 1; illegal select -> IDLE.
REQ-019 Decode: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9, 0x00->0xF (blank); dp bit excluded from decode.
REQ-020 Any other 7-bit pattern SHALL store nibble 0xE and pulse o_seg_err in the capture cycle.
REQ-021 Recapture of a digit whose mask bit is already set SHALL overwrite the shadow nibble/dp; mask unchanged.
REQ-022 When the mask becomes 0xFF, the next cycle SHALL copy shadow to o_bcd8d/o_dp, pulse o_frame_valid, and clear the mask.
REQ-023 If a capture coincides with the frame-commit cycle, that capture SHALL set its mask bit for the next frame and SHALL NOT alter the committed value.
REQ-024 Timeout counter: cleared on every capture, saturates at TIMEOUT_CYC; o_active = 1 iff counter < TIMEOUT_CYC and at least one frame committed since reset.
REQ-025 On timeout, the mask SHALL be cleared; o_bcd8d/o_dp hold their last values.
REQ-026 Out-of-order digit sequences SHALL be accepted; only mask completeness triggers a frame.

Reset
REQ-027 i_rst high SHALL immediately force: FSM IDLE, counters 0, mask 0, shadow 0, o_bcd8d = 0xFFFFFFFF, o_dp = 0, o_frame_valid = 0, o_seg_err = 0, o_active = 0.
REQ-028 Reset asserted mid-frame or in the commit cycle SHALL win; partial captures are discarded.
REQ-029 After deassertion, the first frame requires captures of all 8 digits.

Verification
REQ-030 Scan digits 0..7 with patterns for "12345678" (digit 0 = '8'), each held 10 cycles -> one o_frame_valid, o_bcd8d = 0x12345678, o_dp = 0, o_active = 1.
REQ-031 Digit held only SETTLE_CYC-1 cycles, then next digit -> that digit not captured; no frame until it is rescanned for >= SETTLE_CYC cycles.
REQ-032 Digit 3 seg = 0x49 with dp set -> o_seg_err pulses once; frame shows nibble 3 = 0xE and o_dp[3] = 1.
REQ-033 i_seg_com = 0xFC (two low) for 20 cycles between digits -> no capture, FSM in IDLE, subsequent frame correct.
REQ-034 Scan stops after one frame for TIMEOUT_CYC cycles -> o_active falls exactly when the counter reaches TIMEOUT_CYC; o_bcd8d unchanged.
REQ-035 i_rst pulse after 5 of 8 digits captured -> outputs at reset values immediately; the next frame needs all 8 digits.
